// File: rtl/acc_driver.sv
// acc_driver: feeds 512-bit message blocks into a memory-mapped hash accelerator
// one 32-bit word per cycle, kicks it off, collects the 8 result words it
// writes back, and hands the 256-bit hash downstream with a valid/ready handshake.
//
// Optional build macro ACC_DRIVER_TIMEOUT_EN adds a WAIT-state watchdog of
// TIMEOUT_CYCLES cycles; on expiry the job is acknowledged, err pulses for one
// cycle and the driver returns to IDLE without presenting a hash.
//
// state | meaning
// IDLE  | ready for a new block
// LOAD  | writing block words 0..15 to accelerator addresses 0..15
// START | writing the start command to the control address
// WAIT  | capturing result words until the done marker arrives
// ACK   | writing the acknowledge command to the control address
// OUT   | presenting the hash until downstream takes it

module acc_driver #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    output logic         acc_chipselect,
    output logic         acc_write,
    output logic [4:0]   acc_address,
    output logic [31:0]  acc_writedata,
    input  logic [31:0]  acc_data_in,
    input  logic [3:0]   acc_waddr_in,
    output logic         hash_valid,
    input  logic         hash_ready,
    output logic [255:0] hash_out,
    output logic         err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        ACK   = 3'd4,
        OUT   = 3'd5
    } state_t;

    localparam logic [4:0]  CTRL_ADDR = 5'd16;
    localparam logic [31:0] CMD_START = 32'hFFFF_FFFF;
    localparam logic [31:0] CMD_ACK   = 32'h0F0F_0F0F;

    state_t             state_q;
    state_t             state_d;
    logic [3:0]         word_idx_q;
    logic [511:0]       blk_q;
    logic [7:0][31:0]   res_q;
    logic               marker;
    logic               wd_expire;

    // Index 8 only counts as "done" together with the all-ones data word.
    assign marker = (acc_waddr_in == 4'h8) && (acc_data_in == 32'hFFFF_FFFF);

`ifdef ACC_DRIVER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             timed_out_q;

    assign wd_expire = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign err       = (state_q == ACK) && timed_out_q;

    // Watchdog: counts WAIT cycles since START; remembers whether WAIT was left by expiry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q  <= '0;
            timed_out_q <= 1'b0;
        end else if (state_q == START) begin
            wait_cnt_q  <= '0;
            timed_out_q <= 1'b0;
        end else if (state_q == WAIT) begin
            wait_cnt_q  <= wait_cnt_q + CNT_W'(1);
            timed_out_q <= !marker && wd_expire;
        end
    end
`else
    logic unused_timeout;

    // Without the watchdog the limit has no meaning; it is folded away here.
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign wd_expire      = 1'b0;
    assign err            = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Block latch on handshake and word index walk during LOAD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blk_q      <= '0;
            word_idx_q <= '0;
        end else if ((state_q == IDLE) && blk_valid) begin
            blk_q      <= blk_data;
            word_idx_q <= '0;
        end else if (state_q == LOAD) begin
            word_idx_q <= word_idx_q + 4'd1;
        end
    end

    // Result capture in WAIT; later writes to the same index overwrite earlier ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_q <= '0;
        end else if ((state_q == WAIT) && !acc_waddr_in[3]) begin
            res_q[acc_waddr_in[2:0]] <= acc_data_in;
        end
    end

    // Next-state and output decode; bus outputs are zero unless a write is issued.
    always_comb begin
        state_d        = state_q;
        blk_ready      = 1'b0;
        acc_chipselect = 1'b0;
        acc_write      = 1'b0;
        acc_address    = '0;
        acc_writedata  = '0;
        hash_valid     = 1'b0;
        hash_out       = '0;
        unique case (state_q)
            IDLE: begin
                // Held low while reset is asserted so the block never advertises readiness in reset.
                blk_ready = reset;
                if (blk_valid) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                acc_chipselect = 1'b1;
                acc_write      = 1'b1;
                acc_address    = {1'b0, word_idx_q};
                acc_writedata  = blk_q[{word_idx_q, 5'd0} +: 32];
                if (word_idx_q == 4'd15) begin
                    state_d = START;
                end
            end
            START: begin
                acc_chipselect = 1'b1;
                acc_write      = 1'b1;
                acc_address    = CTRL_ADDR;
                acc_writedata  = CMD_START;
                state_d        = WAIT;
            end
            WAIT: begin
                if (marker || wd_expire) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                acc_chipselect = 1'b1;
                acc_write      = 1'b1;
                acc_address    = CTRL_ADDR;
                acc_writedata  = CMD_ACK;
                state_d        = err ? IDLE : OUT;
            end
            OUT: begin
                hash_valid = 1'b1;
                hash_out   = res_q;
                if (hash_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/acc_driver.md
ACC_DRIVER -- requirements
Module: acc_driver

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYCLES, default 4096, WAIT-state watchdog limit in clk cycles (used only with ACC_DRIVER_TIMEOUT_EN).
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous active-low reset; asserted at 0.
REQ-005 blk_valid  input  1  upstream offers a 512-bit message block.
REQ-006 blk_ready  output  1  driver accepts a block; high only in IDLE.
REQ-007 blk_data  input  512  block; word k = bits [32k+31:32k], k=0..15.
REQ-008 acc_chipselect  output  1  accelerator chipselect.
REQ-009 acc_write  output  1  accelerator write strobe.
REQ-010 acc_address  output  5  accelerator word address: 0..15 data, 16 control.
REQ-011 acc_writedata  output  32  accelerator write data.
REQ-012 acc_data_in  input  32  accelerator result word (its data_out).
REQ-013 acc_waddr_in  input  4  accelerator result index (its writeaddress); 0..7 hash word, 8 done marker.
REQ-014 hash_valid  output  1  256-bit result available.
REQ-015 hash_ready  input  1  downstream takes result.
REQ-016 hash_out  output  256  result; word k = bits [32k+31:32k].
REQ-017 err  output  1  one-cycle pulse on watchdog expiry.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, START, WAIT, ACK, OUT.
REQ-019 IDLE: blk_ready=1; on blk_valid&blk_ready, latch blk_data, clear word index, go LOAD.
REQ-020 LOAD: 16 consecutive cycles, cycle k drives chipselect=write=1, address=k, writedata=latched word k; after k=15 go START.
REQ-021 START: one cycle, chipselect=write=1, address=16, writedata=32'hFFFFFFFF; go WAIT.
REQ-022 Outside LOAD/START/ACK, acc_chipselect, acc_write, acc_address, acc_writedata SHALL be 0.
REQ-023 WAIT: every cycle with acc_waddr_in[3]=0, capture acc_data_in into result word acc_waddr_in[2:0]; later captures overwrite earlier ones.
REQ-024 WAIT: marker is acc_waddr_in=4'h8 AND acc_data_in=32'hFFFFFFFF; on marker go ACK; index 8 with any other data SHALL be ignored.
REQ-025 ACK: one cycle, chipselect=write=1, address=16, writedata=32'h0F0F0F0F; go OUT.
REQ-026 OUT: hash_valid=1, hash_out = captured words; both held stable until hash_ready=1, then IDLE next cycle.
REQ-027 hash_out SHALL be 0 outside OUT; result register retains value but is not exposed.
REQ-028 Latency: handshake in cycle t -> first data write cycle t+1, start write t+17; marker sampled cycle m -> ack write m+1, hash_valid m+2.
REQ-029 blk_valid outside IDLE SHALL be ignored; no block queued.
REQ-030 Accelerator has no waitrequest; driver SHALL issue one write per cycle without stalls.

Reset
REQ-031 On reset=0, asynchronously: FSM to IDLE, word index 0, latched block and result words 0, all outputs 0 except blk_ready (1 after release in IDLE).
REQ-032 Reset mid-operation SHALL abandon the job with no further accelerator writes; accelerator state is not recovered by this block.

Configuration
REQ-033 Macro ACC_DRIVER_TIMEOUT_EN defined: WAIT counter cleared on entry, increments each WAIT cycle; on reaching TIMEOUT_CYCLES without marker, issue ACK write, pulse err one cycle, return IDLE (skip OUT).
REQ-034 ACC_DRIVER_TIMEOUT_EN undefined: no counter, err tied 0, WAIT exits only on marker.

Verification
REQ-035 blk_data word k=32'h10000000+k, handshake cycle t -> cycles t+1..t+16 writes addr k data 10000000+k, t+17 addr 16 data FFFFFFFF.
REQ-036 Responder model drives waddr 0..7 data A0000000+k then {8,FFFFFFFF} -> one ack write addr 16 data 0F0F0F0F, then hash_valid=1, hash_out word k=A0000000+k.
REQ-037 In WAIT drive waddr 0 data 11111111 then DEADBEEF, then {8,12345678}, then marker -> {8,12345678} ignored, word 0 = DEADBEEF.
REQ-038 hash_ready low 5 cycles in OUT -> hash_valid, hash_out stable, blk_ready=0, no acc writes; hash_ready=1 -> IDLE next cycle.
REQ-039 ACC_DRIVER_TIMEOUT_EN with TIMEOUT_CYCLES=32, no marker -> ack write after 32 WAIT cycles, err one-cycle pulse, IDLE, hash_valid never 1; undefined -> stays WAIT.
REQ-040 reset=0 during LOAD word 5 -> all acc_* outputs 0 immediately, IDLE after release, no word 6 write.
